// File: rtl/turn_arbiter.sv
// turn_arbiter: turn-based arbiter that shares the keyboard direction stream
// between two player movement blocks. Each accepted move goes to the player
// whose turn it is. A cooldown follows, and then the turn passes to the other
// player. The arbiter also provides pause handling and per-player move counts.
// Optional feature: define TURN_TIMEOUT_EN to build the turn-forfeit timeout.
// In the default build, timeout_pulse is tied to 0.
module turn_arbiter #(
    parameter int unsigned CNT_W           = 28,
    parameter int unsigned COOLDOWN_CYCLES = 2_500_000,
    parameter int unsigned TIMEOUT_CYCLES  = 250_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_en,
    input  logic       pause,
    input  logic       move_up,
    input  logic       move_down,
    input  logic       move_left,
    input  logic       move_right,
    output logic       p1_up,
    output logic       p1_down,
    output logic       p1_left,
    output logic       p1_right,
    output logic       p2_up,
    output logic       p2_down,
    output logic       p2_left,
    output logic       p2_right,
    output logic       turn,
    output logic [1:0] state,
    output logic [7:0] moves_p1,
    output logic [7:0] moves_p2,
    output logic       timeout_pulse
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        LOCKOUT = 2'd2,
        PAUSED  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LOAD   = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             cur_state, state_n;
    state_t             saved_state, saved_n;
    logic               turn_n;
    logic [CNT_W-1:0]   counter, cnt_n;
    logic [3:0]         p1_q, p1_n;      // {up, down, left, right}
    logic [3:0]         p2_q, p2_n;
    logic [7:0]         m1_n, m2_n;
    logic               to_n;
    logic [3:0]         win;

    assign state = cur_state;
    assign {p1_up, p1_down, p1_left, p1_right} = p1_q;
    assign {p2_up, p2_down, p2_left, p2_right} = p2_q;

    // Register state, the timer, the forwarded pulses and the counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state     <= IDLE;
            saved_state   <= ARMED;
            turn          <= 1'b0;
            counter       <= '0;
            p1_q          <= '0;
            p2_q          <= '0;
            moves_p1      <= '0;
            moves_p2      <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            cur_state     <= state_n;
            saved_state   <= saved_n;
            turn          <= turn_n;
            counter       <= cnt_n;
            p1_q          <= p1_n;
            p2_q          <= p2_n;
            moves_p1      <= m1_n;
            moves_p2      <= m2_n;
            timeout_pulse <= to_n;
        end
    end

    // Next-state and output decode. Priority order: game_en low, then pause,
    // then an accepted move, then timer expiry.
    always_comb begin
        state_n = cur_state;
        saved_n = saved_state;
        turn_n  = turn;
        cnt_n   = counter;
        p1_n    = '0;
        p2_n    = '0;
        m1_n    = moves_p1;
        m2_n    = moves_p2;
        to_n    = 1'b0;

        win = '0;
        if (move_up)         win = 4'b1000;
        else if (move_down)  win = 4'b0100;
        else if (move_left)  win = 4'b0010;
        else if (move_right) win = 4'b0001;

        if (!game_en) begin
            state_n = IDLE;
            turn_n  = 1'b0;
        end else begin
            case (cur_state)
                IDLE: begin
                    state_n = ARMED;
                    turn_n  = 1'b0;
                    cnt_n   = TO_LOAD;
                end
                ARMED: begin
                    if (pause) begin
                        state_n = PAUSED;
                        saved_n = ARMED;
                    end else if (win != 4'b0000) begin
                        if (turn) begin
                            p2_n = win;
                            m2_n = moves_p2 + 8'd1;
                        end else begin
                            p1_n = win;
                            m1_n = moves_p1 + 8'd1;
                        end
                        state_n = LOCKOUT;
                        cnt_n   = COOL_LOAD;
                    end
`ifdef TURN_TIMEOUT_EN
                    else if (counter == '0) begin
                        to_n   = 1'b1;
                        turn_n = ~turn;
                        cnt_n  = TO_LOAD;
                    end else begin
                        cnt_n = counter - CNT_W'(1);
                    end
`endif
                end
                LOCKOUT: begin
                    if (pause) begin
                        state_n = PAUSED;
                        saved_n = LOCKOUT;
                    end else if (counter == '0) begin
                        state_n = ARMED;
                        turn_n  = ~turn;
                        cnt_n   = TO_LOAD;
                    end else begin
                        cnt_n = counter - CNT_W'(1);
                    end
                end
                PAUSED: begin
                    if (!pause) state_n = saved_state;
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_turn_arbiter.sv
// Directed testbench for turn_arbiter with COOLDOWN_CYCLES=4 and TIMEOUT_CYCLES=10.
// The timeout section follows whether TURN_TIMEOUT_EN is defined.
module tb_turn_arbiter;

    logic clk = 1'b0;
    logic rst, game_en, pause;
    logic move_up, move_down, move_left, move_right;
    logic p1_up, p1_down, p1_left, p1_right;
    logic p2_up, p2_down, p2_left, p2_right;
    logic turn, timeout_pulse;
    logic [1:0] state;
    logic [7:0] moves_p1, moves_p2;

    int checks = 0;
    int errors = 0;

    turn_arbiter #(
        .CNT_W(8),
        .COOLDOWN_CYCLES(4),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .clk(clk), .rst(rst), .game_en(game_en), .pause(pause),
        .move_up(move_up), .move_down(move_down),
        .move_left(move_left), .move_right(move_right),
        .p1_up(p1_up), .p1_down(p1_down), .p1_left(p1_left), .p1_right(p1_right),
        .p2_up(p2_up), .p2_down(p2_down), .p2_left(p2_left), .p2_right(p2_right),
        .turn(turn), .state(state), .moves_p1(moves_p1), .moves_p2(moves_p2),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ge;
        logic       pa;
        logic [3:0] mv;
        logic [3:0] p1;
        logic [3:0] p2;
        logic       tn;
        logic [1:0] st;
        logic [7:0] m1;
        logic [7:0] m2;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string nm, input logic [3:0] ep1, input logic [3:0] ep2,
                              input logic et, input logic [1:0] est,
                              input logic [7:0] em1, input logic [7:0] em2, input logic eto);
        check({nm, ".p1"}, {28'd0, p1_up, p1_down, p1_left, p1_right}, {28'd0, ep1});
        check({nm, ".p2"}, {28'd0, p2_up, p2_down, p2_left, p2_right}, {28'd0, ep2});
        check({nm, ".turn"}, {31'd0, turn}, {31'd0, et});
        check({nm, ".state"}, {30'd0, state}, {30'd0, est});
        check({nm, ".moves_p1"}, {24'd0, moves_p1}, {24'd0, em1});
        check({nm, ".moves_p2"}, {24'd0, moves_p2}, {24'd0, em2});
        check({nm, ".timeout"}, {31'd0, timeout_pulse}, {31'd0, eto});
    endtask

    // Drive inputs for one cycle, then sample 1 time unit after the rising edge.
    task automatic step(input logic ge, input logic pa, input logic [3:0] mv);
        game_en = ge;
        pause   = pa;
        {move_up, move_down, move_left, move_right} = mv;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] em1, em2;
    logic       et;
    logic       saw_to;

    initial begin
        //          ge    pa    mv       p1       p2       tn    st     m1     m2
        tbl[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd1, 8'd0, 8'd0};
        tbl[1]  = '{1'b1, 1'b0, 4'b1000, 4'b1000, 4'b0000, 1'b0, 2'd2, 8'd1, 8'd0};
        tbl[2]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd2, 8'd1, 8'd0};
        tbl[3]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd2, 8'd1, 8'd0};
        tbl[4]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd2, 8'd1, 8'd0};
        tbl[5]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd1, 8'd1, 8'd0};
        tbl[6]  = '{1'b1, 1'b0, 4'b0011, 4'b0000, 4'b0010, 1'b1, 2'd2, 8'd1, 8'd1};
        tbl[7]  = '{1'b1, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1, 2'd2, 8'd1, 8'd1};
        tbl[8]  = '{1'b1, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1, 2'd2, 8'd1, 8'd1};
        tbl[9]  = '{1'b1, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1, 2'd2, 8'd1, 8'd1};
        tbl[10] = '{1'b1, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd1, 8'd1, 8'd1};
        tbl[11] = '{1'b1, 1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd3, 8'd1, 8'd1};
        tbl[12] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd1, 8'd1, 8'd1};
        tbl[13] = '{1'b1, 1'b0, 4'b0111, 4'b0100, 4'b0000, 1'b0, 2'd2, 8'd2, 8'd1};
        tbl[14] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd2, 8'd2, 8'd1};

        rst = 1'b0; game_en = 1'b0; pause = 1'b0;
        {move_up, move_down, move_left, move_right} = 4'b0000;
        #7;
        check_outs("reset", 4'h0, 4'h0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0);
        #5 rst = 1'b1;   // t=12, away from the edge at t=15

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].ge, tbl[i].pa, tbl[i].mv);
            check_outs($sformatf("vec%0d", i), tbl[i].p1, tbl[i].p2, tbl[i].tn,
                       tbl[i].st, tbl[i].m1, tbl[i].m2, 1'b0);
        end

        // The pause begins while the lockout counter is 2, and moves offered during it are dropped.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, (i % 2 == 0) ? 4'b1000 : 4'b0010);
            check_outs($sformatf("pause%0d", i), 4'h0, 4'h0, 1'b0, 2'd3, 8'd2, 8'd1, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 4'b0000);
            check_outs($sformatf("resume%0d", i), 4'h0, 4'h0, 1'b0, 2'd2, 8'd2, 8'd1, 1'b0);
        end
        step(1'b1, 1'b0, 4'b0000);
        check_outs("resume_end", 4'h0, 4'h0, 1'b1, 2'd1, 8'd2, 8'd1, 1'b0);
        em1 = 8'd2; em2 = 8'd1;

`ifdef TURN_TIMEOUT_EN
        for (int k = 1; k <= 9; k++) begin
            step(1'b1, 1'b0, 4'b0000);
            check_outs($sformatf("to_wait%0d", k), 4'h0, 4'h0, 1'b1, 2'd1, em1, em2, 1'b0);
        end
        step(1'b1, 1'b0, 4'b0000);
        check_outs("to_fire", 4'h0, 4'h0, 1'b0, 2'd1, em1, em2, 1'b1);
        for (int k = 11; k <= 19; k++) begin
            step(1'b1, 1'b0, 4'b0000);
            check_outs($sformatf("to_wait%0d", k), 4'h0, 4'h0, 1'b0, 2'd1, em1, em2, 1'b0);
        end
        // A move in the expiry cycle is forwarded, and no timeout occurs.
        step(1'b1, 1'b0, 4'b1000);
        em1 = em1 + 8'd1;
        check_outs("to_move_wins", 4'b1000, 4'h0, 1'b0, 2'd2, em1, em2, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 4'b0000);
            check_outs($sformatf("to_lock%0d", k), 4'h0, 4'h0, 1'b0, 2'd2, em1, em2, 1'b0);
        end
        step(1'b1, 1'b0, 4'b0000);
        check_outs("to_lock_end", 4'h0, 4'h0, 1'b1, 2'd1, em1, em2, 1'b0);
`else
        saw_to = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            step(1'b1, 1'b0, 4'b0000);
            if (timeout_pulse !== 1'b0) saw_to = 1'b1;
        end
        check("no_timeout_pulse", {31'd0, saw_to}, 32'd0);
        check_outs("armed_1000", 4'h0, 4'h0, 1'b1, 2'd1, em1, em2, 1'b0);
`endif

        // game_en low takes priority over both pause and a move. The counts are retained.
        step(1'b0, 1'b1, 4'b1000);
        check_outs("gedrop", 4'h0, 4'h0, 1'b0, 2'd0, em1, em2, 1'b0);
        step(1'b0, 1'b0, 4'b0000);
        check_outs("idle_hold", 4'h0, 4'h0, 1'b0, 2'd0, em1, em2, 1'b0);
        step(1'b1, 1'b0, 4'b1000);
        check_outs("idle_move_ignored", 4'h0, 4'h0, 1'b0, 2'd1, em1, em2, 1'b0);
        step(1'b1, 1'b0, 4'b0100);
        em1 = em1 + 8'd1;
        check_outs("rearm_move", 4'b0100, 4'h0, 1'b0, 2'd2, em1, em2, 1'b0);
        step(1'b1, 1'b0, 4'b0000);
        check_outs("pre_rst", 4'h0, 4'h0, 1'b0, 2'd2, em1, em2, 1'b0);
        // An asynchronous reset in the middle of a cycle, during LOCKOUT.
        #2 rst = 1'b0;
        #1;
        check_outs("async_rst", 4'h0, 4'h0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Wrap the counts from 255 to 0 by making 256 accepted moves per player.
        step(1'b1, 1'b0, 4'b0000);
        check_outs("wrap_arm", 4'h0, 4'h0, 1'b0, 2'd1, 8'd0, 8'd0, 1'b0);
        em1 = 8'd0; em2 = 8'd0; et = 1'b0;
        for (int i = 0; i < 512; i++) begin
            step(1'b1, 1'b0, 4'b0001);
            if (et) em2 = em2 + 8'd1; else em1 = em1 + 8'd1;
            if (i >= 508)
                check_outs($sformatf("wrap%0d", i), et ? 4'h0 : 4'b0001,
                           et ? 4'b0001 : 4'h0, et, 2'd2, em1, em2, 1'b0);
            for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 4'b0000);
            et = ~et;
        end
        check("wrap_p1", {24'd0, moves_p1}, 32'd0);
        check("wrap_p2", {24'd0, moves_p2}, 32'd0);
        check("wrap_turn", {31'd0, turn}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
